lcd_timing_gen: RTL and testbench
=================================

LCD_TIMING_GEN -- requirements
Module: lcd_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, 800, visible pixels per line.
REQ-002 Parameter H_FP, 40, horizontal front porch, in pixel clocks.
REQ-003 Parameter H_SYNC, 128, HSYNC pulse width, in pixel clocks.
REQ-004 Parameter H_BP, 88, horizontal back porch; line total is 1056 clocks.
REQ-005 Parameter V_ACTIVE, 480, visible lines per frame.
REQ-006 Parameter V_FP, 13, vertical front porch, in lines.
REQ-007 Parameter V_SYNC, 3, VSYNC pulse width, in lines.
REQ-008 Parameter V_BP, 32, vertical back porch; frame total is 528 lines.
REQ-009 Port CLK  input  1  pixel clock (33.33 MHz); all logic on its rising edge.
REQ-010 Port nRST  input  1  asynchronous active-low reset.
REQ-011 Port HSYNC  output  1  horizontal sync, active-low.
REQ-012 Port VSYNC  output  1  vertical sync, active-low.
REQ-013 Port DE  output  1  data enable, high for visible pixels.
REQ-014 Port X  output  10  pixel column, 0..H_ACTIVE-1, valid while DE.
REQ-015 Port Y  output  10  pixel row, 0..V_ACTIVE-1, valid while DE.
REQ-016 Port FRAME_END  output  1  high throughout vertical blanking; its falling edge marks the start of a frame.
REQ-017 Port FRAME_CNT  output  16  completed-frame counter; wraps from 0xFFFF to 0.

Function
REQ-018 Internal h_cnt SHALL count 0..1055 and wrap to 0; v_cnt SHALL advance by one only when h_cnt wraps, and count 0..527 before wrapping to 0.
REQ-019 The horizontal state machine SHALL follow H_ACT -> H_FRONT -> H_SYNCP -> H_BACK -> H_ACT, with transitions at h_cnt = 800, 840, 968 and 1056 (wrap).
REQ-020 The vertical state machine SHALL follow V_ACT -> V_FRONT -> V_SYNCP -> V_BACK -> V_ACT, with transitions at v_cnt = 480, 493, 496 and 528 (wrap), evaluated only on h_cnt wrap.
REQ-021 All outputs SHALL be registered and SHALL reflect the counter state with exactly 1 CLK of latency.
REQ-022 DE SHALL be high iff the H state is H_ACT and the V state is V_ACT.
REQ-023 HSYNC SHALL be low iff the H state is H_SYNCP, on every line including blanking lines.
REQ-024 VSYNC SHALL be low iff the V state is V_SYNCP, for whole lines, with edges aligned to h_cnt = 0.
REQ-025 X SHALL equal h_cnt and Y SHALL equal v_cnt while DE is high; outside DE, X and Y SHALL be 0.
REQ-026 FRAME_END SHALL rise with the first clock of line 480 and fall with the first clock of line 0.
REQ-027 FRAME_CNT SHALL increment by 1 in the same cycle that FRAME_END rises.
REQ-028 No output SHALL glitch or take an out-of-range value at wrap points, including the simultaneous h/v wrap at (1055, 527).
REQ-029 Parameter sums SHALL be computed at 11-bit width so that totals never overflow.

Reset
REQ-030 While nRST is low: h_cnt = 0, v_cnt = 0, both state machines in ACT, HSYNC = 1, VSYNC = 1, DE = 0, X = 0, Y = 0, FRAME_END = 0, FRAME_CNT = 0.
REQ-031 Reset asserted mid-line or mid-frame SHALL return all outputs to their reset values immediately and asynchronously.
REQ-032 After nRST deasserts, the first rising CLK edge SHALL begin pixel (0,0); DE SHALL go high 1 CLK later.

Structure
REQ-033 The timing defaults, state encodings and totals SHALL live in the shared package lcd_pkg, for reuse by the bitmap and compositing stages.
REQ-034 One sub-module, lcd_phase_counter (counter plus 4-phase FSM, parameterised by the phase lengths and an advance enable), SHALL be instantiated twice: once for horizontal and once for vertical.

Verification
REQ-035 Release reset and run 2 frames -> exactly 1056 clocks between HSYNC falling edges, HSYNC low for 128 clocks, 384000 DE-high clocks per frame.
REQ-036 Sample at the first DE edge of a frame -> X = 0, Y = 0; at the last DE clock of the frame -> X = 799, Y = 479.
REQ-037 Track VSYNC across a frame -> low for 3 × 1056 clocks, falling edge coincident with h_cnt = 0 of line 493; FRAME_END high for 48 lines.
REQ-038 Force FRAME_CNT to 0xFFFF and complete one frame -> FRAME_CNT = 0x0000, incremented on the FRAME_END rising edge.
REQ-039 Pulse nRST low at line 200, pixel 400 -> outputs return to reset values with no clock; after release, (0,0) restarts and DE returns after 1 CLK.
REQ-040 Instantiate with 4/1/1/1 h and 2/1/1/1 v -> totals 7 × 5, and state sequences per REQ-019 and REQ-020 with no skipped phase.

Source files
------------

// File: rtl/lcd_pkg.sv
// lcd_pkg: shared LCD timing definitions.
// Holds the default 800x480 panel timing, the 4-phase state encoding used by
// both the horizontal and vertical sequencers, the counter widths, and the
// helper that adds phase lengths at counter width so totals cannot overflow.
// Reused by the timing generator and by the downstream bitmap/compositing stages.
package lcd_pkg;

    localparam int LCD_H_ACTIVE = 800;
    localparam int LCD_H_FP     = 40;
    localparam int LCD_H_SYNC   = 128;
    localparam int LCD_H_BP     = 88;

    localparam int LCD_V_ACTIVE = 480;
    localparam int LCD_V_FP     = 13;
    localparam int LCD_V_SYNC   = 3;
    localparam int LCD_V_BP     = 32;

    // Internal position counters hold up to 1055; the exported coordinate only
    // needs to cover the active region (0..799).
    localparam int CNT_W = 11;
    localparam int POS_W = 10;

    typedef enum logic [1:0] {
        PH_ACT   = 2'd0,
        PH_FRONT = 2'd1,
        PH_SYNCP = 2'd2,
        PH_BACK  = 2'd3
    } phase_e;

    // Sum of phase lengths evaluated at CNT_W bits.
    function automatic logic [CNT_W-1:0] phase_sum(input int a, input int b,
                                                   input int c, input int d);
        return CNT_W'(a) + CNT_W'(b) + CNT_W'(c) + CNT_W'(d);
    endfunction

    localparam logic [CNT_W-1:0] LCD_H_TOTAL =
        phase_sum(LCD_H_ACTIVE, LCD_H_FP, LCD_H_SYNC, LCD_H_BP);   // 1056
    localparam logic [CNT_W-1:0] LCD_V_TOTAL =
        phase_sum(LCD_V_ACTIVE, LCD_V_FP, LCD_V_SYNC, LCD_V_BP);   // 528

endpackage

// File: rtl/lcd_phase_counter.sv
// lcd_phase_counter: position counter with a 4-phase sequencer
// (ACT -> FRONT -> SYNCP -> BACK -> ACT). Used once per axis.
// Ports:
//   i_clk    clock, rising edge
//   i_rst_n  asynchronous active-low reset (count 0, phase ACT)
//   i_adv    advance enable; counter and phase only move when high
//   o_pos    low POS_W bits of the position (meaningful during ACT)
//   o_phase  current phase, always consistent with the current count
//   o_wrap   high when the next advance returns the count to 0
module lcd_phase_counter
    import lcd_pkg::*;
#(
    parameter int LEN_ACT   = LCD_H_ACTIVE,
    parameter int LEN_FRONT = LCD_H_FP,
    parameter int LEN_SYNC  = LCD_H_SYNC,
    parameter int LEN_BACK  = LCD_H_BP
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_adv,
    output logic [POS_W-1:0] o_pos,
    output phase_e           o_phase,
    output logic             o_wrap
);

    localparam logic [CNT_W-1:0] END_ACT   = phase_sum(LEN_ACT, 0, 0, 0);
    localparam logic [CNT_W-1:0] END_FRONT = phase_sum(LEN_ACT, LEN_FRONT, 0, 0);
    localparam logic [CNT_W-1:0] END_SYNC  = phase_sum(LEN_ACT, LEN_FRONT, LEN_SYNC, 0);
    localparam logic [CNT_W-1:0] LAST      =
        phase_sum(LEN_ACT, LEN_FRONT, LEN_SYNC, LEN_BACK) - CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [CNT_W-1:0] w_cnt_next;
    phase_e           r_phase;
    phase_e           w_phase_next;
    logic             w_last;

    assign w_cnt_inc = r_cnt + CNT_W'(1);
    assign w_last    = (r_cnt == LAST);

    // Phase changes are decided from the incremented count so that the
    // registered phase always matches the registered count, even for
    // phases only one step long.
    always_comb begin
        w_cnt_next   = r_cnt;
        w_phase_next = r_phase;
        if (i_adv) begin
            w_cnt_next = w_last ? '0 : w_cnt_inc;
            case (r_phase)
                PH_ACT:   if (w_cnt_inc == END_ACT)   w_phase_next = PH_FRONT;
                PH_FRONT: if (w_cnt_inc == END_FRONT) w_phase_next = PH_SYNCP;
                PH_SYNCP: if (w_cnt_inc == END_SYNC)  w_phase_next = PH_BACK;
                PH_BACK:  if (w_last)                 w_phase_next = PH_ACT;
                default:                              w_phase_next = PH_ACT;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt   <= '0;
            r_phase <= PH_ACT;
        end else begin
            r_cnt   <= w_cnt_next;
            r_phase <= w_phase_next;
        end
    end

    assign o_pos   = r_cnt[POS_W-1:0];
    assign o_phase = r_phase;
    assign o_wrap  = i_adv && w_last;

endmodule

// File: rtl/lcd_timing_gen.sv
// lcd_timing_gen: LCD panel timing generator (default 800x480, 1056x528 total).
// Ports:
//   CLK        pixel clock, rising edge
//   nRST       asynchronous active-low reset
//   HSYNC      horizontal sync, active-low
//   VSYNC      vertical sync, active-low, whole lines
//   DE         data enable, high for visible pixels
//   X, Y       pixel column/row while DE, 0 otherwise
//   FRAME_END  high during vertical blanking; falling edge starts a frame
//   FRAME_CNT  completed-frame counter, increments as FRAME_END rises
// All outputs are registered decodes of the counter state (1 CLK latency).
module lcd_timing_gen
    import lcd_pkg::*;
#(
    parameter int H_ACTIVE = LCD_H_ACTIVE,
    parameter int H_FP     = LCD_H_FP,
    parameter int H_SYNC   = LCD_H_SYNC,
    parameter int H_BP     = LCD_H_BP,
    parameter int V_ACTIVE = LCD_V_ACTIVE,
    parameter int V_FP     = LCD_V_FP,
    parameter int V_SYNC   = LCD_V_SYNC,
    parameter int V_BP     = LCD_V_BP
) (
    input  logic        CLK,
    input  logic        nRST,
    output logic        HSYNC,
    output logic        VSYNC,
    output logic        DE,
    output logic [9:0]  X,
    output logic [9:0]  Y,
    output logic        FRAME_END,
    output logic [15:0] FRAME_CNT
);

    logic [POS_W-1:0] w_h_pos;
    logic [POS_W-1:0] w_v_pos;
    phase_e           w_h_phase;
    phase_e           w_v_phase;
    logic             w_h_wrap;
    // The vertical carry has no consumer: frame boundaries come from the phase.
    logic             w_unused_v_wrap;
    logic             w_de;
    logic             w_fe;

    logic             r_hsync;
    logic             r_vsync;
    logic             r_de;
    logic [9:0]       r_x;
    logic [9:0]       r_y;
    logic             r_frame_end;
    logic [15:0]      r_frame_cnt;

    lcd_phase_counter #(
        .LEN_ACT   (H_ACTIVE),
        .LEN_FRONT (H_FP),
        .LEN_SYNC  (H_SYNC),
        .LEN_BACK  (H_BP)
    ) u_h (
        .i_clk   (CLK),
        .i_rst_n (nRST),
        .i_adv   (1'b1),
        .o_pos   (w_h_pos),
        .o_phase (w_h_phase),
        .o_wrap  (w_h_wrap)
    );

    // Vertical position only moves at the end of each line, so VSYNC and
    // FRAME_END edges land on h_cnt = 0.
    lcd_phase_counter #(
        .LEN_ACT   (V_ACTIVE),
        .LEN_FRONT (V_FP),
        .LEN_SYNC  (V_SYNC),
        .LEN_BACK  (V_BP)
    ) u_v (
        .i_clk   (CLK),
        .i_rst_n (nRST),
        .i_adv   (w_h_wrap),
        .o_pos   (w_v_pos),
        .o_phase (w_v_phase),
        .o_wrap  (w_unused_v_wrap)
    );

    assign w_de = (w_h_phase == PH_ACT) && (w_v_phase == PH_ACT);
    assign w_fe = (w_v_phase != PH_ACT);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_hsync     <= 1'b1;
            r_vsync     <= 1'b1;
            r_de        <= 1'b0;
            r_x         <= '0;
            r_y         <= '0;
            r_frame_end <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_hsync     <= (w_h_phase != PH_SYNCP);
            r_vsync     <= (w_v_phase != PH_SYNCP);
            r_de        <= w_de;
            r_x         <= w_de ? w_h_pos : '0;
            r_y         <= w_de ? w_v_pos : '0;
            r_frame_end <= w_fe;
            // Rising edge of FRAME_END is detected against its own register.
            r_frame_cnt <= r_frame_cnt + 16'(w_fe && !r_frame_end);
        end
    end

    assign HSYNC     = r_hsync;
    assign VSYNC     = r_vsync;
    assign DE        = r_de;
    assign X         = r_x;
    assign Y         = r_y;
    assign FRAME_END = r_frame_end;
    assign FRAME_CNT = r_frame_cnt;

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Testbench for lcd_timing_gen: a default-timing instance (f), a medium
// instance (m, 25x13 total) and the minimal 4/1/1/1 x 2/1/1/1 instance (s).
module tb_lcd_timing_gen;

    logic CLK = 1'b0;
    logic nRST;

    always #5 CLK = ~CLK;

    logic f_hs, f_vs, f_de, f_fe;
    logic [9:0] f_x, f_y;
    logic [15:0] f_fc;
    logic m_hs, m_vs, m_de, m_fe;
    logic [9:0] m_x, m_y;
    logic [15:0] m_fc;
    logic s_hs, s_vs, s_de, s_fe;
    logic [9:0] s_x, s_y;
    logic [15:0] s_fc;

    lcd_timing_gen dut_f (
        .CLK(CLK), .nRST(nRST), .HSYNC(f_hs), .VSYNC(f_vs), .DE(f_de),
        .X(f_x), .Y(f_y), .FRAME_END(f_fe), .FRAME_CNT(f_fc)
    );

    lcd_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
        .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3)
    ) dut_m (
        .CLK(CLK), .nRST(nRST), .HSYNC(m_hs), .VSYNC(m_vs), .DE(m_de),
        .X(m_x), .Y(m_y), .FRAME_END(m_fe), .FRAME_CNT(m_fc)
    );

    lcd_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) dut_s (
        .CLK(CLK), .nRST(nRST), .HSYNC(s_hs), .VSYNC(s_vs), .DE(s_de),
        .X(s_x), .Y(s_y), .FRAME_END(s_fe), .FRAME_CNT(s_fc)
    );

    // {HSYNC, VSYNC, DE, X, Y, FRAME_END, FRAME_CNT}
    localparam logic [39:0] RST_VEC = {1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 1'b0, 16'd0};

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected outputs for the n-th clock after reset release, derived from
    // pixel position arithmetic.
    function automatic logic [39:0] model(input int n,
                                          input int ha, input int hf, input int hs, input int hb,
                                          input int va, input int vf, input int vs, input int vb);
        int ht = ha + hf + hs + hb;
        int vt = va + vf + vs + vb;
        int ft = ht * vt;
        int h  = n % ht;
        int v  = (n / ht) % vt;
        logic de  = (h < ha) && (v < va);
        logic hsy = !((h >= ha + hf) && (h < ha + hf + hs));
        logic vsy = !((v >= va + vf) && (v < va + vf + vs));
        logic [9:0] x = de ? 10'(h) : 10'd0;
        logic [9:0] y = de ? 10'(v) : 10'd0;
        logic fe = (v >= va);
        logic [15:0] fc = 16'(n / ft + (((n % ft) >= va * ht) ? 1 : 0));
        return {hsy, vsy, de, x, y, fe, fc};
    endfunction

    function automatic logic [39:0] mf(input int n);
        return model(n, 800, 40, 128, 88, 480, 13, 3, 32);
    endfunction
    function automatic logic [39:0] mm(input int n);
        return model(n, 16, 2, 3, 4, 6, 2, 2, 3);
    endfunction
    function automatic logic [39:0] ms(input int n);
        return model(n, 4, 1, 1, 1, 2, 1, 1, 1);
    endfunction

    int f_fall1 = -1, f_fall2 = -1, f_rise1 = -1;
    logic f_hs_prev = 1'b1;
    int m_de_cnt = 0, m_vs_low = 0, m_fe_hi = 0, m_vs_fall = -1;
    logic m_vs_prev = 1'b1;
    int k;
    logic found;
    logic [15:0] fc_before;

    initial begin
        // Reset state
        nRST = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_f", 64'({f_hs, f_vs, f_de, f_x, f_y, f_fe, f_fc}), 64'(RST_VEC));
        check("rst_m", 64'({m_hs, m_vs, m_de, m_x, m_y, m_fe, m_fc}), 64'(RST_VEC));
        check("rst_s", 64'({s_hs, s_vs, s_de, s_x, s_y, s_fe, s_fc}), 64'(RST_VEC));
        nRST = 1'b1;

        // Free run: cycle-by-cycle comparison plus edge measurements
        for (int n = 0; n < 2000; n++) begin
            @(negedge CLK);
            check($sformatf("vec_f n=%0d", n), 64'({f_hs, f_vs, f_de, f_x, f_y, f_fe, f_fc}), 64'(mf(n)));
            check($sformatf("vec_m n=%0d", n), 64'({m_hs, m_vs, m_de, m_x, m_y, m_fe, m_fc}), 64'(mm(n)));
            check($sformatf("vec_s n=%0d", n), 64'({s_hs, s_vs, s_de, s_x, s_y, s_fe, s_fc}), 64'(ms(n)));
            if (f_hs_prev && !f_hs) begin
                if (f_fall1 < 0) f_fall1 = n;
                else if (f_fall2 < 0) f_fall2 = n;
            end
            if (!f_hs_prev && f_hs && f_rise1 < 0) f_rise1 = n;
            f_hs_prev = f_hs;
            if (n < 325) begin
                m_de_cnt += int'(m_de);
                m_vs_low += int'(!m_vs);
                m_fe_hi  += int'(m_fe);
            end
            if (m_vs_prev && !m_vs && m_vs_fall < 0) m_vs_fall = n;
            m_vs_prev = m_vs;
            if (n == 0) begin
                check("first_de_s", 64'({s_de, s_x, s_y}), 64'({1'b1, 10'd0, 10'd0}));
                check("first_de_f", 64'({f_de, f_x, f_y}), 64'({1'b1, 10'd0, 10'd0}));
            end
            if (n == 10) check("last_de_s", 64'({s_de, s_x, s_y}), 64'({1'b1, 10'd3, 10'd1}));
            if (n == 11) check("after_last_de_s", 64'({s_de, s_x, s_y}), 64'({1'b0, 10'd0, 10'd0}));
            if (n == 799) check("line_end_f", 64'({f_de, f_x}), 64'({1'b1, 10'd799}));
            if (n == 800) check("front_f", 64'({f_de, f_x}), 64'({1'b0, 10'd0}));
            if (n == 149) check("fc_pre_m", 64'({m_fe, m_fc}), 64'({1'b0, 16'd0}));
            if (n == 150) check("fc_rise_m", 64'({m_fe, m_fc}), 64'({1'b1, 16'd1}));
        end
        check("hsync_first_fall_f", 64'(f_fall1), 64'(840));
        check("hsync_period_f", 64'(f_fall2 - f_fall1), 64'(1056));
        check("hsync_width_f", 64'(f_rise1 - f_fall1), 64'(128));
        check("de_per_frame_m", 64'(m_de_cnt), 64'(96));
        check("vsync_low_m", 64'(m_vs_low), 64'(50));
        check("frame_end_hi_m", 64'(m_fe_hi), 64'(175));
        check("vsync_fall_m", 64'(m_vs_fall), 64'(200));

        // Mid-frame asynchronous reset
        #2;
        nRST = 1'b0;
        #1;
        check("async_rst_f", 64'({f_hs, f_vs, f_de, f_x, f_y, f_fe, f_fc}), 64'(RST_VEC));
        check("async_rst_m", 64'({m_hs, m_vs, m_de, m_x, m_y, m_fe, m_fc}), 64'(RST_VEC));
        check("async_rst_s", 64'({s_hs, s_vs, s_de, s_x, s_y, s_fe, s_fc}), 64'(RST_VEC));
        @(negedge CLK);
        check("held_rst_m", 64'({m_hs, m_vs, m_de, m_x, m_y, m_fe, m_fc}), 64'(RST_VEC));
        nRST = 1'b1;
        for (int n = 0; n < 400; n++) begin
            @(negedge CLK);
            check($sformatf("re_f n=%0d", n), 64'({f_hs, f_vs, f_de, f_x, f_y, f_fe, f_fc}), 64'(mf(n)));
            check($sformatf("re_m n=%0d", n), 64'({m_hs, m_vs, m_de, m_x, m_y, m_fe, m_fc}), 64'(mm(n)));
            check($sformatf("re_s n=%0d", n), 64'({s_hs, s_vs, s_de, s_x, s_y, s_fe, s_fc}), 64'(ms(n)));
            if (n == 0) check("restart_m", 64'({m_de, m_x, m_y}), 64'({1'b1, 10'd0, 10'd0}));
        end

        // Frame counter wrap from 0xFFFF
        force dut_m.r_frame_cnt = 16'hFFFF;
        @(negedge CLK);
        k = 400;
        release dut_m.r_frame_cnt;
        check("fc_forced_m", 64'(m_fc), 64'(16'hFFFF));
        fc_before = m_fc;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK);
            k++;
            if (m_fe) begin
                found = 1'b1;
                break;
            end
            fc_before = m_fc;
        end
        check("fe_rise_seen_m", 64'(found), 64'(1));
        check("fe_rise_time_m", 64'(k), 64'(475));
        check("fc_before_wrap_m", 64'(fc_before), 64'(16'hFFFF));
        check("fc_wrapped_m", 64'(m_fc), 64'(16'h0000));
        @(negedge CLK);
        check("fc_hold_m", 64'({m_fe, m_fc}), 64'({1'b1, 16'h0000}));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
